overlay_mixer: RTL

OVERLAY_MIXER -- requirements
Module: overlay_mixer

---
 rtl/overlay_mixer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/overlay_mixer.sv
// overlay_mixer: keyed text overlay with frame-stepped fade in/hold/fade out and 1-cycle registered output
module overlay_mixer #(
    parameter int STEP_FRAMES = 8,
    parameter int HOLD_FRAMES = 120,
    parameter int GAP_FRAMES  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] bg_rgb,
    input  logic [5:0] ovl_rgb,
    input  logic       active_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       frame_start,
    input  logic       enable,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [2:0] ovl_level,
    output logic       busy
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FADE_IN  = 3'd1;
    localparam logic [2:0] HOLD     = 3'd2;
    localparam logic [2:0] FADE_OUT = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;
    localparam logic [5:0] KEY      = 6'b100001;

    logic [2:0] state, state_nx, level_nx;
    logic [7:0] cnt, cnt_nx;
    logic [5:0] mix;
    logic       step_hit, hold_hit, gap_hit;

    function automatic logic [1:0] blend(input logic [1:0] o, input logic [1:0] b, input logic [2:0] l);
        logic [3:0] s;
        s = 4'(o) * 4'(l) + 4'(b) * 4'(3'd4 - l);
        return s[3:2];
    endfunction

    assign step_hit = cnt == 8'(STEP_FRAMES - 1);
    assign hold_hit = cnt == 8'(HOLD_FRAMES - 1);
    assign gap_hit  = cnt == 8'(GAP_FRAMES - 1);
    assign busy     = state != IDLE;

    always_comb begin
        mix = !active_in ? 6'd0 :
              ovl_rgb == KEY ? bg_rgb :
              {blend(ovl_rgb[5:4], bg_rgb[5:4], ovl_level),
               blend(ovl_rgb[3:2], bg_rgb[3:2], ovl_level),
               blend(ovl_rgb[1:0], bg_rgb[1:0], ovl_level)};
    end

    // Everything in the sequencer moves only on frame_start, so a frame never sees two levels.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = ovl_level;
        if (frame_start) begin
            cnt_nx = cnt + 8'd1;
            case (state)
                IDLE: begin
                    cnt_nx   = 8'd0;
                    state_nx = enable ? FADE_IN : IDLE;
                end
                FADE_IN: begin
                    if (!enable) begin
                        state_nx = FADE_OUT;
                        cnt_nx   = 8'd0;
                    end else if (step_hit) begin
                        cnt_nx   = 8'd0;
                        level_nx = ovl_level + 3'd1;
                        state_nx = ovl_level == 3'd3 ? HOLD : FADE_IN;
                    end
                end
                HOLD: begin
                    if (!enable || hold_hit) begin
                        state_nx = FADE_OUT;
                        cnt_nx   = 8'd0;
                    end
                end
                FADE_OUT: begin
                    if (step_hit) begin
                        cnt_nx   = 8'd0;
                        level_nx = ovl_level == 3'd0 ? 3'd0 : ovl_level - 3'd1;
                        state_nx = ovl_level <= 3'd1 ? GAP : FADE_OUT;
                    end
                end
                GAP: begin
                    if (gap_hit) begin
                        state_nx = IDLE;
                        cnt_nx   = 8'd0;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                    level_nx = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ovl_level <= 3'd0;
            rgb_out   <= 6'd0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ovl_level <= level_nx;
            rgb_out   <= mix;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end
endmodule
